// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl: sequencing controller and two-way arbiter for one shared serial
// shift-add signed multiplier datapath (A:X:B registers plus adder/subtractor).
//
// Each job takes 2*WIDTH+3 cycles, counting the IDLE cycle in which the request is
// sampled. The job runs LOAD once, then ADD and SHIFT alternately for WIDTH bits,
// then DONE.
//
// Ports:
//   Clk, Reset           clock; synchronous active-high reset
//   req_i[1:0]           per-requester job request (level)
//   op_a0_i, op_b0_i     requester 0 multiplicand / multiplier
//   op_a1_i, op_b1_i     requester 1 multiplicand / multiplier
//   m_i                  datapath multiplier LSB (current bit)
//   grant_o[1:0]         one-hot datapath owner, 0 when idle
//   busy_o               high in every non-idle state
//   load_o               datapath parallel load (clears A, loads X/B)
//   add_o, sub_o         A <= A +/- multiplicand
//   shift_o              arithmetic right shift of A:B
//   opa_o, opb_o         operands of the granted requester, 0 when idle
//   done_o[1:0]          one-cycle completion pulse to the served requester
//
// Build option: define PRIORITY_FIXED_EN for fixed priority, where requester 0
// always wins ties. Without it, ties are resolved round-robin.
module mult_share_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [1:0]       req_i,
  input  logic [WIDTH-1:0] op_a0_i,
  input  logic [WIDTH-1:0] op_b0_i,
  input  logic [WIDTH-1:0] op_a1_i,
  input  logic [WIDTH-1:0] op_b1_i,
  input  logic             m_i,
  output logic [1:0]       grant_o,
  output logic             busy_o,
  output logic             load_o,
  output logic             add_o,
  output logic             sub_o,
  output logic             shift_o,
  output logic [WIDTH-1:0] opa_o,
  output logic [WIDTH-1:0] opb_o,
  output logic [1:0]       done_o
);

  localparam int unsigned    CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StAdd, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
`ifndef PRIORITY_FIXED_EN
  // Index of the requester served most recently; reset to 1 so requester 0 wins the first tie.
  logic              last_q, last_d;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
      grant_q <= 2'b00;
      cnt_q   <= '0;
`ifndef PRIORITY_FIXED_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
`ifndef PRIORITY_FIXED_EN
      last_q  <= last_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
`ifndef PRIORITY_FIXED_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req_i != 2'b00) begin
          state_d = StLoad;
`ifdef PRIORITY_FIXED_EN
          grant_d = req_i[0] ? 2'b01 : 2'b10;
`else
          if (req_i == 2'b11) grant_d = last_q ? 2'b01 : 2'b10;
          else                grant_d = req_i;
`endif
        end
      end
      StLoad: begin
        cnt_d   = '0;
        state_d = StAdd;
      end
      StAdd: state_d = StShift;
      StShift: begin
        cnt_d   = cnt_q + CntW'(1);
        state_d = (cnt_q == CntLast) ? StDone : StAdd;
      end
      StDone: begin
`ifndef PRIORITY_FIXED_EN
        last_d  = grant_q[1];
`endif
        grant_d = 2'b00;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        grant_d = 2'b00;
      end
    endcase
  end

  // Strobes decode from registered state only (plus the current multiplier bit).
  // The final bit is the two's-complement sign bit, so it subtracts instead of adding.
  always_comb begin
    grant_o = grant_q;
    busy_o  = (state_q != StIdle);
    load_o  = (state_q == StLoad);
    add_o   = (state_q == StAdd) && m_i && (cnt_q != CntLast);
    sub_o   = (state_q == StAdd) && m_i && (cnt_q == CntLast);
    shift_o = (state_q == StShift);
    done_o  = (state_q == StDone) ? grant_q : 2'b00;
    opa_o   = '0;
    opb_o   = '0;
    if (grant_q[0]) begin
      opa_o = op_a0_i;
      opb_o = op_b0_i;
    end else if (grant_q[1]) begin
      opa_o = op_a1_i;
      opb_o = op_b1_i;
    end
  end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Testbench for mult_share_ctrl. A job-level model tracks the owner and the cycle
// offset since the grant, and the expected outputs come from that offset. Directed
// jobs also pin literal cycle numbers and strobe counts.
module tb_mult_share_ctrl;
  localparam int unsigned W = 8;

  logic         Clk = 1'b0;
  logic         Reset;
  logic [1:0]   req;
  logic [W-1:0] op_a0, op_b0, op_a1, op_b1;
  logic         m_bit;
  logic         m_rand = 1'b0;
  logic [1:0]   grant_o, done_o;
  logic         busy_o, load_o, add_o, sub_o, shift_o;
  logic [W-1:0] opa_o, opb_o;

  int total = 0;
  int bad   = 0;

  mult_share_ctrl #(.WIDTH(W)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .req_i   (req),
    .op_a0_i (op_a0),
    .op_b0_i (op_b0),
    .op_a1_i (op_a1),
    .op_b1_i (op_b1),
    .m_i     (m_bit),
    .grant_o (grant_o),
    .busy_o  (busy_o),
    .load_o  (load_o),
    .add_o   (add_o),
    .sub_o   (sub_o),
    .shift_o (shift_o),
    .opa_o   (opa_o),
    .opb_o   (opb_o),
    .done_o  (done_o)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- job-level model ----------------
  int m_owner = -1;   // -1 idle, else requester index
  int m_t     = 0;    // cycles since the grant took effect
  int m_last  = 1;
  bit m_valid = 1'b0;

  function automatic int winner(input logic [1:0] r);
    if (r == 2'b01) return 0;
    if (r == 2'b10) return 1;
`ifdef PRIORITY_FIXED_EN
    return 0;
`else
    return 1 - m_last;
`endif
  endfunction

  always @(posedge Clk) begin
    if (Reset) begin
      m_owner = -1; m_t = 0; m_last = 1; m_valid = 1'b1;
    end else if (m_valid) begin
      if (m_owner < 0) begin
        if (req != 2'b00) begin m_owner = winner(req); m_t = 0; end
      end else if (m_t == 2 * W + 1) begin
        m_last = m_owner; m_owner = -1;
      end else begin
        m_t++;
      end
    end
  end

  always @(posedge Clk) if (m_rand) begin #1; m_bit = 1'($urandom_range(1, 0)); end

  logic [1:0]   e_grant, e_done;
  logic         e_busy, e_load, e_add, e_sub, e_shift;
  logic [W-1:0] e_opa, e_opb;
  int           k_bit;

  always @(negedge Clk) if (m_valid) begin
    e_grant = (m_owner < 0) ? 2'b00 : 2'(1 << m_owner);
    e_busy  = (m_owner >= 0);
    e_load  = e_busy && (m_t == 0);
    k_bit   = (m_t - 1) / 2;
    e_add   = e_busy && (m_t % 2 == 1) && (m_t <= 2 * W) && m_bit && (k_bit < W - 1);
    e_sub   = e_busy && (m_t % 2 == 1) && (m_t <= 2 * W) && m_bit && (k_bit == W - 1);
    e_shift = e_busy && (m_t % 2 == 0) && (m_t >= 2) && (m_t <= 2 * W);
    e_done  = (e_busy && m_t == 2 * W + 1) ? e_grant : 2'b00;
    e_opa   = (m_owner == 0) ? op_a0 : (m_owner == 1) ? op_a1 : '0;
    e_opb   = (m_owner == 0) ? op_b0 : (m_owner == 1) ? op_b1 : '0;
    chk("grant", 32'(grant_o), 32'(e_grant));
    chk("busy", 32'(busy_o), 32'(e_busy));
    chk("load", 32'(load_o), 32'(e_load));
    chk("add", 32'(add_o), 32'(e_add));
    chk("sub", 32'(sub_o), 32'(e_sub));
    chk("shift", 32'(shift_o), 32'(e_shift));
    chk("done", 32'(done_o), 32'(e_done));
    chk("opa", 32'(opa_o), 32'(e_opa));
    chk("opb", 32'(opb_o), 32'(e_opb));
    chk("grant_onehot0", 32'($onehot0(grant_o)), 32'd1);
    chk("add_sub_excl", 32'(add_o & sub_o), 32'd0);
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
  endtask

  task automatic next_idle();
    @(posedge Clk);
    #1;
  endtask

  // Tallies strobes from cycle 'start' until done pulses. At drop_at, req and op_a0
  // change just after the following edge.
  task automatic run_job(input int start, input int drop_at, output int dcyc,
                         output int n_add, output int n_sub, output int n_shift,
                         output int n_load, output logic [1:0] g1, output logic [1:0] dval);
    dcyc = -1; n_add = 0; n_sub = 0; n_shift = 0; n_load = 0; g1 = 2'b00; dval = 2'b00;
    for (int k = start; k < start + 60; k++) begin
      @(negedge Clk);
      if (k == start + 1) g1 = grant_o;
      n_add   += int'(add_o === 1'b1);
      n_sub   += int'(sub_o === 1'b1);
      n_shift += int'(shift_o === 1'b1);
      n_load  += int'(load_o === 1'b1);
      if (done_o != 2'b00) begin
        dcyc = k; dval = done_o;
        break;
      end
      if (k == drop_at) begin
        @(posedge Clk);
        #1 req = 2'b00; op_a0 = ~op_a0;
      end
    end
    if (dcyc < 0) begin
      total++; bad++;
      $display("FAIL job_timeout: got no done want done within 60 cycles");
    end
  endtask

  int dc, na, ns, nsh, nl, ndone;
  logic [1:0] g1, dv;

  initial begin
    Reset = 1'b1; req = 2'b00; m_bit = 1'b0;
    op_a0 = '0; op_b0 = '0; op_a1 = '0; op_b1 = '0;
    do_reset();

    // 1: single request, M held 1
    op_a0 = 8'h07; op_b0 = 8'hFF; m_bit = 1'b1; req = 2'b01;
    run_job(0, -1, dc, na, ns, nsh, nl, g1, dv);
    chk("t1_grant_c1", 32'(g1), 32'h1);
    chk("t1_done_cyc", 32'(dc), 32'd18);
    chk("t1_done_val", 32'(dv), 32'h1);
    chk("t1_n_add", 32'(na), 32'd7);
    chk("t1_n_sub", 32'(ns), 32'd1);
    chk("t1_n_shift", 32'(nsh), 32'd8);
    chk("t1_n_load", 32'(nl), 32'd1);
    req = 2'b00;
    @(negedge Clk);
    chk("t1_busy_c19", 32'(busy_o), 32'd0);
    next_idle();

    // 2: tie from reset; requester 1 runs with a random multiplier bit stream
    do_reset();
    op_a1 = 8'h81; op_b1 = 8'h3C; req = 2'b11;
    run_job(0, -1, dc, na, ns, nsh, nl, g1, dv);
    chk("t2_first_done_cyc", 32'(dc), 32'd18);
    chk("t2_first_done_val", 32'(dv), 32'h1);
    req = 2'b10; m_rand = 1'b1;
    run_job(19, -1, dc, na, ns, nsh, nl, g1, dv);
    chk("t2_second_grant", 32'(g1), 32'h2);
    chk("t2_second_done_cyc", 32'(dc), 32'd37);
    chk("t2_second_done_val", 32'(dv), 32'h2);
    m_rand = 1'b0; m_bit = 1'b1; req = 2'b00;
    next_idle();

    // 2b: both requests held across DONE
    do_reset();
    req = 2'b11;
    run_job(0, -1, dc, na, ns, nsh, nl, g1, dv);
    run_job(19, -1, dc, na, ns, nsh, nl, g1, dv);
    chk("t2b_done_cyc", 32'(dc), 32'd37);
`ifdef PRIORITY_FIXED_EN
    chk("t2b_done_val", 32'(dv), 32'h1);
`else
    chk("t2b_done_val", 32'(dv), 32'h2);
`endif
    req = 2'b00;
    next_idle();

    // 3: M held 0
    m_bit = 1'b0; op_a0 = 8'h55; op_b0 = 8'h00; req = 2'b01;
    run_job(0, -1, dc, na, ns, nsh, nl, g1, dv);
    chk("t3_done_cyc", 32'(dc), 32'd18);
    chk("t3_n_add", 32'(na), 32'd0);
    chk("t3_n_sub", 32'(ns), 32'd0);
    chk("t3_n_shift", 32'(nsh), 32'd8);
    req = 2'b00;
    next_idle();

    // 4: reset at cycle 9 of a job
    m_bit = 1'b1; req = 2'b01;
    for (int k = 0; k <= 9; k++) @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1 Reset = 1'b0; req = 2'b00;
    @(negedge Clk);
    chk("t4_grant_c10", 32'(grant_o), 32'h0);
    chk("t4_busy_c10", 32'(busy_o), 32'd0);
    chk("t4_strobes_c10", 32'({load_o, add_o, sub_o, shift_o}), 32'h0);
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge Clk);
      ndone += int'(done_o != 2'b00);
    end
    chk("t4_no_done", 32'(ndone), 32'd0);
    next_idle();
    req = 2'b11;
    run_job(0, -1, dc, na, ns, nsh, nl, g1, dv);
    chk("t4_tie_after_reset", 32'(g1), 32'h1);
    req = 2'b00;
    next_idle();
    req = 2'b10;
    run_job(0, -1, dc, na, ns, nsh, nl, g1, dv);
    chk("t4_req1_grant", 32'(g1), 32'h2);
    chk("t4_req1_done_cyc", 32'(dc), 32'd18);
    req = 2'b00;
    next_idle();

    // 5: req dropped and operand changed mid-job
    op_a0 = 8'hA5; op_b0 = 8'h5A; m_bit = 1'b1; req = 2'b01;
    run_job(0, 4, dc, na, ns, nsh, nl, g1, dv);
    chk("t5_done_cyc", 32'(dc), 32'd18);
    chk("t5_done_val", 32'(dv), 32'h1);
    chk("t5_n_add", 32'(na), 32'd7);
    chk("t5_n_sub", 32'(ns), 32'd1);
    chk("t5_n_shift", 32'(nsh), 32'd8);
    repeat (10) @(negedge Clk);
    chk("t5_no_regrant", 32'(grant_o), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish want finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
